load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data path width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  load result, 0 for stores and errors.
REQ-013 SHALL have port resp_error  output  1  misaligned or illegal request, valid with resp_valid.
REQ-014 SHALL have port mem_address  output  32  byte address to data RAM, bits[1:0] always 0.
REQ-015 SHALL have port mem_data_write  output  32  RAM write data.
REQ-016 SHALL have port mem_write_en  output  1  RAM write strobe, committed at clk edge.
REQ-017 SHALL have port mem_read_en  output  1  RAM read enable.
REQ-018 SHALL have port mem_data_out  input  32  RAM combinational read data, valid same cycle as mem_read_en.

Function
REQ-019 SHALL implement FSM states INIT, IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-020 SHALL spend exactly one cycle in INIT after reset with req_ready=0, giving the RAM its preload cycle, then enter IDLE.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready, and all request fields are latched then.
REQ-022 SHALL flag an error when req_size=11, when halfword and addr[0]=1, or when word and addr[1:0]!=0; no RAM access is made and the unit goes to RESP with resp_error=1.
REQ-023 Load: SHALL go to LOAD for one cycle (mem_read_en=1), capture the extracted data, then go to RESP. Response arrives 2 cycles after acceptance.
REQ-024 Word store: SHALL go to WRITE for one cycle (mem_write_en=1, mem_data_write=req_wdata), then go to RESP. Response arrives 2 cycles after acceptance.
REQ-025 Sub-word store: SHALL go to RMW_READ (mem_read_en=1, word captured), then WRITE with the merged word, then go to RESP. Response arrives 3 cycles after acceptance.
REQ-026 Byte lanes SHALL be little-endian: byte offset k occupies bits [8k+7:8k]; halfword offset 0 uses [15:0], offset 2 uses [31:16].
REQ-027 Sub-word loads SHALL zero-extend when req_signed=0 and sign-extend from the top bit of the byte or half when req_signed=1.
REQ-028 Merge SHALL replace only the addressed lane with the low 8/16 bits of req_wdata; other lanes come from the captured word unchanged.
REQ-029 mem_address SHALL be {req_addr[31:2],2'b00} in LOAD/RMW_READ/WRITE and 0 otherwise.
REQ-030 mem_read_en, mem_write_en and mem_data_write SHALL be 0 outside their states, so read and write enables are never high together.
REQ-031 resp_valid SHALL be high for exactly one cycle in RESP, and SHALL then go to IDLE; req_valid is ignored outside IDLE.

Reset
REQ-032 While reset=1, SHALL go to INIT and drive all outputs to 0, including req_ready and resp_valid.
REQ-033 Reset mid-operation SHALL abandon the request with no write in the reset cycle and no response.

Structure
REQ-034 SHALL place the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encoding in shared package lsu_pkg.
REQ-035 SHALL place lane extract/sign-extend and store-merge logic in combinational sub-module lsu_byte_lane.

Verification
REQ-036 Word load addr 0x8, RAM word 0x12345678 -> resp 2 cycles after accept, rdata=0x12345678, error=0.
REQ-037 Signed byte load addr 0x7, RAM word@0x4 = 0x80FF0011 -> rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 Byte store 0xAB to addr 0x5 over word 0x11223344 -> RMW read then write 0x1122AB44, resp 3 cycles after accept.
REQ-039 Halfword load addr 0x3 -> resp 1 cycle after accept with error=1, mem_read_en and mem_write_en never asserted.
REQ-040 Reset pulsed during the WRITE state -> no mem_write_en that cycle, no resp, req_ready=0 one cycle after reset release then 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state encoding and the request legality check.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    LOAD     = 3'd2,
    RMW_READ = 3'd3,
    WRITE    = 3'd4,
    RESP     = 3'd5
  } lsu_state_t;

  // True when a request can never be served: illegal size or an offset
  // that does not sit on a natural boundary for the access size.
  function automatic logic lsu_bad_req(input logic [1:0] size,
                                       input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane steering: extracts and extends sub-word load data from
// a RAM word, and merges sub-word store data into a captured RAM word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/half lane out of the RAM word.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  // Zero- or sign-extend the selected lane to the full load result.
  always_comb begin
    o_load = i_word;
    case (i_size)
      SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  // Replace only the addressed lane; a full word store takes the data as is.
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        case (i_offset)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (i_offset[1]) o_merged[31:16] = i_wdata[15:0];
        else             o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, performs the RAM read,
// write or read-modify-write, and returns a single-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [31:0]           mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_write,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  lsu_state_t r_state;
  lsu_state_t w_next;

  logic [1:0]            r_size;
  logic                  r_signed;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_store;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_bad;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_bad    = lsu_bad_req(req_size, req_addr[1:0]);
  assign w_accept = req_valid && req_ready;

  lsu_byte_lane u_lane (
    .i_size   (r_size),
    .i_offset (r_addr[1:0]),
    .i_signed (r_signed),
    .i_word   (mem_data_out),
    .i_wdata  (r_store),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // State register; reset always returns to INIT for the RAM preload cycle.
  always_ff @(posedge clk) begin
    if (reset) r_state <= INIT;
    else       r_state <= w_next;
  end

  // Request latch, load capture and store-word assembly (data only, no reset).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_store  <= req_wdata;
      r_rdata  <= '0;
      r_err    <= w_bad;
    end
    if (r_state == LOAD)     r_rdata <= w_load;
    if (r_state == RMW_READ) r_store <= w_merged;
  end

  // Next-state and outputs; reset forces every output low combinationally so
  // an in-flight write is dropped in the reset cycle itself.
  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_error     = 1'b0;
    mem_address    = '0;
    mem_data_write = '0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    case (r_state)
      INIT: w_next = IDLE;
      IDLE: begin
        if (req_valid) begin
          if (w_bad)                   w_next = RESP;
          else if (!req_write)         w_next = LOAD;
          else if (req_size == SZ_WORD) w_next = WRITE;
          else                         w_next = RMW_READ;
        end
      end
      LOAD:     w_next = RESP;
      RMW_READ: w_next = WRITE;
      WRITE:    w_next = RESP;
      RESP:     w_next = IDLE;
      default:  w_next = INIT;
    endcase
    if (!reset) begin
      case (r_state)
        IDLE: req_ready = 1'b1;
        LOAD, RMW_READ: begin
          mem_read_en = 1'b1;
          mem_address = {r_addr[31:2], 2'b00};
        end
        WRITE: begin
          mem_write_en   = 1'b1;
          mem_data_write = r_store;
          mem_address    = {r_addr[31:2], 2'b00};
        end
        RESP: begin
          resp_valid = 1'b1;
          resp_rdata = r_rdata;
          resp_error = r_err;
        end
        default: ;
      endcase
    end
  end

endmodule
